// File: rtl/line_drawer_pkg.sv
// Shared types and helpers for the Bresenham line rasteriser.
// Width helpers are constant functions, so the top can size its datapath from its own parameters.
package line_drawer_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, PLOT} state_t;

    localparam int HOR_DEFAULT = 640;
    localparam int VER_DEFAULT = 480;

    // Two extra bits cover the sign and the dx+dy sum without overflow.
    function automatic int err_width(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 2;
    endfunction

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Returns 1 when the walk runs towards smaller coordinates.
    function automatic logic step_neg(input int from, input int to);
        return !(from < to);
    endfunction

endpackage

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: one segment per start pulse, one pixel per cycle over a
// valid/ready port. Off-screen pixels are still walked (one cycle each) but never emitted.
module line_drawer
    import line_drawer_pkg::*;
#(
    parameter  int HOR_ACTIVE_PIXELS = HOR_DEFAULT,
    parameter  int VER_ACTIVE_PIXELS = VER_DEFAULT,
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y2,
    output logic               pix_valid,
    output logic [X_WIDTH-1:0] pix_x,
    output logic [Y_WIDTH-1:0] pix_y,
    input  logic               pix_ready
);

    localparam int ERR_W = err_width(X_WIDTH, Y_WIDTH);
    localparam int E2_W  = ERR_W + 1;
    localparam logic [X_WIDTH:0] HOR_LIM = (X_WIDTH+1)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH:0] VER_LIM = (Y_WIDTH+1)'(VER_ACTIVE_PIXELS);

    typedef struct packed {
        logic [X_WIDTH-1:0]      x;
        logic [Y_WIDTH-1:0]      y;
        logic signed [ERR_W-1:0] err;
    } walk_t;

    state_t                  state;
    logic [X_WIDTH-1:0]      x1_r, x2_r, cx;
    logic [Y_WIDTH-1:0]      y1_r, y2_r, cy;
    logic signed [ERR_W-1:0] dx, dy, err;
    logic                    sx_neg, sy_neg;
    logic signed [ERR_W-1:0] dx_n, dy_n;
    logic                    on, step, at_end;
    walk_t                   cur_w, nxt_w;

    // Both branches test the same e2, so a diagonal move updates x, y and err together.
    function automatic walk_t bres_step(input walk_t cur,
                                        input logic signed [ERR_W-1:0] ddx,
                                        input logic signed [ERR_W-1:0] ddy,
                                        input logic nsx, input logic nsy);
        walk_t                   nxt;
        logic signed [ERR_W-1:0] acc;
        logic signed [E2_W-1:0]  e2;
        nxt = cur;
        acc = cur.err;
        e2  = {cur.err, 1'b0};
        if (e2 >= E2_W'(ddy)) begin
            acc   = acc + ddy;
            nxt.x = nsx ? cur.x - X_WIDTH'(1) : cur.x + X_WIDTH'(1);
        end
        if (e2 <= E2_W'(ddx)) begin
            acc   = acc + ddx;
            nxt.y = nsy ? cur.y - Y_WIDTH'(1) : cur.y + Y_WIDTH'(1);
        end
        nxt.err = acc;
        return nxt;
    endfunction

    assign dx_n   = ERR_W'(abs_diff(int'(x1_r), int'(x2_r)));
    assign dy_n   = -ERR_W'(abs_diff(int'(y1_r), int'(y2_r)));
    assign on     = ({1'b0, cx} < HOR_LIM) && ({1'b0, cy} < VER_LIM);
    assign step   = (state == PLOT) && (!on || pix_ready);
    assign at_end = (cx == x2_r) && (cy == y2_r);
    assign cur_w  = '{x: cx, y: cy, err: err};
    assign nxt_w  = bres_step(cur_w, dx, dy, sx_neg, sy_neg);

    assign pix_valid = (state == PLOT) && on;
    assign pix_x     = cx;
    assign pix_y     = cy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ready  <= 1'b1;
            x1_r   <= '0;
            y1_r   <= '0;
            x2_r   <= '0;
            y2_r   <= '0;
            cx     <= '0;
            cy     <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x1_r  <= x1;
                        y1_r  <= y1;
                        x2_r  <= x2;
                        y2_r  <= y2;
                        state <= SETUP;
                        ready <= 1'b0;
                    end
                end
                SETUP: begin
                    dx     <= dx_n;
                    dy     <= dy_n;
                    err    <= dx_n + dy_n;
                    sx_neg <= step_neg(int'(x1_r), int'(x2_r));
                    sy_neg <= step_neg(int'(y1_r), int'(y2_r));
                    cx     <= x1_r;
                    cy     <= y1_r;
                    state  <= PLOT;
                end
                PLOT: begin
                    if (step) begin
                        if (at_end) begin
                            state <= IDLE;
                            ready <= 1'b1;
                        end else begin
                            cx  <= nxt_w.x;
                            cy  <= nxt_w.y;
                            err <= nxt_w.err;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: a queue-based line model feeds a per-cycle pixel checker,
// with literal pixel lists pinning the model and cycle counts pinning the handshake timing.
module tb_line_drawer;

    localparam int HOR = 640;
    localparam int VER = 480;
    localparam int XW  = 10;
    localparam int YW  = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready;
    logic [XW-1:0] x1 = '0, x2 = '0;
    logic [YW-1:0] y1 = '0, y2 = '0;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_ready;

    line_drawer #(.HOR_ACTIVE_PIXELS(HOR), .VER_ACTIVE_PIXELS(VER)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_ready(pix_ready)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y;} pix_t;
    pix_t exp_q[$];
    pix_t lit_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   stall_x = -1;
    bit   stall_req = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference line walk in plain integers; returns the number of walked positions.
    function automatic int model_line(input int ax, input int ay, input int bx, input int by);
        int ddx, ddy, sx, sy, e, e2, x, y, n;
        ddx = (bx > ax) ? bx - ax : ax - bx;
        ddy = -((by > ay) ? by - ay : ay - by);
        sx  = (ax < bx) ? 1 : -1;
        sy  = (ay < by) ? 1 : -1;
        e   = ddx + ddy;
        x   = ax;
        y   = ay;
        n   = 0;
        forever begin
            n++;
            if (x < HOR && y < VER) exp_q.push_back('{x: x, y: y});
            if (x == bx && y == by) break;
            e2 = 2 * e;
            if (e2 >= ddy) begin e += ddy; x += sx; end
            if (e2 <= ddx) begin e += ddx; y += sy; end
        end
        return n;
    endfunction

    task automatic lit(input int x, input int y);
        lit_q.push_back('{x: x, y: y});
    endtask

    // Per-cycle checker: accepted pixels pop the model queue; stalled pixels must hold.
    logic pv_q = 1'b0, pr_q = 1'b0;
    int   px_q = 0, py_q = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_q <= 1'b0;
        end else begin
            if (pv_q && !pr_q) begin
                chk("stall valid held", int'(pix_valid), 1);
                chk("stall x held", int'(pix_x), px_q);
                chk("stall y held", int'(pix_y), py_q);
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra pixel: got (%0d,%0d), want none", pix_x, pix_y);
                end else begin
                    chk("pixel x", int'(pix_x), exp_q[0].x);
                    chk("pixel y", int'(pix_y), exp_q[0].y);
                    void'(exp_q.pop_front());
                end
            end
            pv_q <= pix_valid;
            pr_q <= pix_ready;
            px_q <= int'(pix_x);
            py_q <= int'(pix_y);
        end
    end

    // Backpressure: on the first sight of pixel x == stall_x, drop pix_ready for 3 cycles.
    initial begin
        int left;
        pix_ready = 1'b1;
        left = 0;
        forever begin
            @(posedge clk);
            #2;
            if (left > 0) begin
                left--;
                if (left == 0) pix_ready = 1'b1;
            end else if (stall_req && pix_valid && int'(pix_x) == stall_x) begin
                pix_ready = 1'b0;
                left      = 3;
                stall_req = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ready before start", int'(ready), 1);
    endtask

    task automatic issue(input int ax, input int ay, input int bx, input int by);
        wait_ready();
        start = 1'b1;
        x1 = XW'(ax); y1 = YW'(ay); x2 = XW'(bx); y2 = YW'(by);
        @(posedge clk);
        #1;
        start = 1'b0;
        x1 = XW'($urandom); y1 = YW'($urandom); x2 = XW'($urandom); y2 = YW'($urandom);
        chk("ready low after accept", int'(ready), 0);
        chk("no pixel in setup", int'(pix_valid), 0);
    endtask

    task automatic draw(input int ax, input int ay, input int bx, input int by,
                        input int stall, input bit poke);
        int walked, k;
        walked = model_line(ax, ay, bx, by);
        if (lit_q.size() > 0) begin
            chk("model length", exp_q.size(), lit_q.size());
            for (int i = 0; i < lit_q.size() && i < exp_q.size(); i++) begin
                chk("model x", exp_q[i].x, lit_q[i].x);
                chk("model y", exp_q[i].y, lit_q[i].y);
            end
            lit_q.delete();
        end
        issue(ax, ay, bx, by);
        k = 1;
        @(posedge clk);
        #1;
        k = 2;
        chk("first pixel valid", int'(pix_valid), (ax < HOR && ay < VER) ? 1 : 0);
        while (!ready && k < walked + stall + 50) begin
            if (poke && k == 5) begin
                start = 1'b1;
                x1 = 10'd50; y1 = 9'd50; x2 = 10'd60; y2 = 9'd60;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
        end
        chk("ready return cycle", k, 2 + walked + stall);
        chk("all pixels emitted", exp_q.size(), 0);
    endtask

    initial begin
        int dummy;
        #12;
        chk("reset ready", int'(ready), 1);
        chk("reset pix_valid", int'(pix_valid), 0);
        chk("reset pix_x", int'(pix_x), 0);
        chk("reset pix_y", int'(pix_y), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        lit(0, 0); lit(1, 1); lit(2, 2); lit(3, 3);
        draw(0, 0, 3, 3, 0, 1'b0);

        lit(0, 0); lit(1, 0); lit(2, 1); lit(3, 1); lit(4, 1);
        draw(0, 0, 4, 1, 0, 1'b0);

        lit(3, 2); lit(2, 2); lit(1, 2); lit(0, 2);
        draw(3, 2, 0, 2, 0, 1'b0);

        lit(5, 5);
        draw(5, 5, 5, 5, 0, 1'b0);

        // Steep line with negative sy and a short endpoint on the bottom edge.
        draw(7, 479, 2, 460, 0, 1'b0);

        draw(0, 225, 640, 225, 0, 1'b0);

        stall_x   = 4;
        stall_req = 1'b1;
        draw(0, 0, 9, 0, 3, 1'b1);
        chk("stall was taken", int'(stall_req), 0);

        // Mid-line abort, then a clean redraw of the same segment.
        dummy = model_line(0, 0, 100, 50);
        issue(0, 0, 100, 50);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort ready", int'(ready), 1);
        chk("abort pix_valid", int'(pix_valid), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("abort still quiet", int'(pix_valid), 0);
        rst_n = 1'b1;
        draw(0, 0, 100, 50, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
